mux_n_1_pipe: RTL

Parametrised N:1 selector with a registered output and valid/ready handshake, the pipelined successor of the fixed 2:1 5-bit combinational mux. It is used where a source select must cross a pipeline boundary, e.g. write-back source select (ALU / memory / PC+4 / immediate) or destination register select between stages. Each input transfer captures the selected operand, its select code and an out-of-range flag, and presents them one cycle later under flow control.

---
 rtl/mux_n_1_pipe.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mux_n_1_pipe.sv
// N:1 operand selector with a registered, valid/ready-handshaked output.
// Optional feature macro: MUX_N_1_SKID_EN (skid register, flop-driven in_ready).
module mux_n_1_pipe #(
    parameter int WIDTH = 32,
    parameter int N = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]   sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    output logic               sel_err,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef struct packed {
        logic             err;
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] data;
    } word_t;

    word_t cap_w;
    word_t main_q;
    logic  valid_q;
    logic  in_fire;
    logic  out_fire;

    // Out-of-range selects produce a zero word flagged with err.
    always_comb begin
        cap_w.data = '0;
        cap_w.err  = 1'b1;
        cap_w.sel  = sel;
        for (int k = 0; k < N; k++) begin
            if (sel == SEL_W'(k)) begin
                cap_w.data = in_bus[k*WIDTH +: WIDTH];
                cap_w.err  = 1'b0;
            end
        end
    end

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = valid_q && out_ready;
    assign out_valid = valid_q;
    assign out_data  = main_q.data;
    assign out_sel   = main_q.sel;
    assign sel_err   = main_q.err;

`ifdef MUX_N_1_SKID_EN

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t state_q;
    word_t  skid_q;
    logic   rdy_q;

    assign in_ready = rdy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_q  <= cap_w;
                        valid_q <= 1'b1;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= cap_w;
                    end else if (in_fire) begin
                        skid_q  <= cap_w;
                        rdy_q   <= 1'b0;
                        state_q <= TWO;
                    end else if (out_fire) begin
                        valid_q <= 1'b0;
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_q  <= skid_q;
                        rdy_q   <= 1'b1;
                        state_q <= ONE;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    valid_q <= 1'b0;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

`else

    assign in_ready = !valid_q || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q  <= '0;
            valid_q <= 1'b0;
        end else if (in_fire) begin
            main_q  <= cap_w;
            valid_q <= 1'b1;
        end else if (out_fire) begin
            valid_q <= 1'b0;
        end
    end

`endif

endmodule
